rf_lo_nco_bank: RTL
===================

Name: rf_lo_nco_bank

Overview:
- Parametrised multi-channel numerically controlled local-oscillator bank for the RF playground designs.
- Generates a quadrature (I/Q) square-wave LO pair per channel from a phase accumulator; the pairs drive the analog mixer switches via the top-level outputs.
- Adds per-channel phase offset, linear frequency sweep and glitch-free shadow/commit reconfiguration through a byte-wide register write port fed from the TT dedicated and bidirectional inputs.

Parameters:
- ACC_W, 16: accumulator/FTW width in bits; multiple of 8, range 8..32.
- NUM_CH, 2: number of LO channels, 1..7.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; low freezes accumulators, sweep and outputs
- cfg_wr  in  1  register write strobe, sampled on rising clk
- cfg_addr  in  6  register address
- cfg_data  in  8  register write data
- lo_i  out  NUM_CH  in-phase LO, one bit per channel
- lo_q  out  NUM_CH  quadrature LO, one bit per channel
- sweep_wrap  out  NUM_CH  one-cycle pulse when a channel's sweep wraps
- commit_busy  out  1  high for the cycle in which a commit is applied

Behaviour:
- Reset (rst_n low, asynchronous): every shadow and active register, accumulator and output is 0. Clearing is immediate, including mid-sweep or mid-commit.
- Register map, per channel c, base = 8*c:
  - +0..+3: FTW bytes, little-endian; bytes at or above ACC_W/8 are ignored.
  - +4: phase offset PH[7:0].
  - +5: control; bit0 EN, bit1 SWEEP.
  - +6: sweep step STEP[7:0].
  - +7: reserved.
- Address 0x3F is COMMIT; cfg_data bit0 = PHASE_RST.
- Writes to unmapped addresses are ignored. No readback.
- Writes land in shadow registers only. The active datapath is unaffected until COMMIT.
- COMMIT sampled at edge t:
  - At edge t, all channels' active FTW/PH/EN/SWEEP/STEP load from shadow simultaneously.
  - If PHASE_RST=1, all accumulators clear to 0 at that same edge.
  - commit_busy is 1 for the cycle following edge t.
- Accumulator, each edge with ena=1 and active EN=1: acc <= acc + ftw_act, mod 2^ACC_W.
  - Active EN=0: acc forced to 0.
  - ena=0: acc, ftw_act and outputs hold; config writes and COMMIT are still accepted.
- Effective phase: p = acc + (PH << (ACC_W-8)), mod 2^ACC_W.
  - lo_i = p[ACC_W-1].
  - lo_q = (p + 2^(ACC_W-2))[ACC_W-1], so Q leads I by 90°.
  - Both are registered from the post-edge acc, giving one cycle of latency; both are 0 when EN=0.
- Sweep (active SWEEP=1, EN=1, ena=1):
  - Each edge: ftw_act <= ftw_act + STEP.
  - If that addition carries out of ACC_W bits, ftw_act reloads instead from the committed base FTW (held separately) and sweep_wrap[c] pulses for one cycle.
  - The accumulator uses the pre-update ftw_act.
- Simultaneous events:
  - A channel write in the same cycle as a COMMIT to a different address is impossible, because there is a single port.
  - COMMIT during a sweep restarts the sweep from the new base FTW.
  - COMMIT with PHASE_RST while ena=0 still clears the accumulators.
- Outputs are glitch-free; every output is a flop output.

Test Plan:
- ACC_W=16, ch0 FTW=0x4000, EN=1, then COMMIT with data=0x01 -> from the first output cycle, lo_i = 0,0,1,1 repeating and lo_q = 0,1,1,0 repeating (period 4 clk).
- Write ch0 FTW=0x2000 with no COMMIT while running at 0x4000 -> period stays 4 clk. Then COMMIT -> period becomes 8 clk on the next cycle with no runt pulse.
- ch1 PH=0x40, both channels FTW=0x4000, COMMIT with PHASE_RST -> lo_i[1] equals lo_q[0] every cycle (90° offset).
- ch0 FTW=0xFFF0, STEP=0x08, SWEEP=1, COMMIT -> ftw_act goes 0xFFF8, then wraps to 0xFFF0 with a one-cycle sweep_wrap[0] pulse, repeating every 2 clk.
- Drop ena for 5 clk mid-run -> lo_i/lo_q hold their values, then resume the exact sequence.
- Assert rst_n mid-sweep, asynchronously between edges -> all outputs go to 0 immediately. After release, outputs stay 0 until a new config is written and committed.

Source files
------------

// File: rtl/rf_lo_nco_bank.sv
// rf_lo_nco_bank: multi-channel quadrature square-wave NCO bank with
// shadow/commit configuration, per-channel phase offset and FTW sweep.
module rf_lo_nco_bank #(
  parameter int ACC_W  = 16,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cfg_wr,
  input  logic [5:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic [NUM_CH-1:0] lo_i,
  output logic [NUM_CH-1:0] lo_q,
  output logic [NUM_CH-1:0] sweep_wrap,
  output logic              commit_busy
);

  localparam logic [ACC_W-1:0] HALF = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] QTR  = {2'b01, {(ACC_W-2){1'b0}}};

  logic commit;
  logic busy_q;

  assign commit      = cfg_wr && (cfg_addr == 6'h3F);
  assign commit_busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= 1'b0;
    else        busy_q <= commit;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic             sel;
    logic [ACC_W-1:0] ftw_sh_q;
    logic [7:0]       ph_sh_q;
    logic [7:0]       step_sh_q;
    logic             en_sh_q;
    logic             sw_sh_q;
    logic [ACC_W-1:0] base_q;
    logic [ACC_W-1:0] ftw_q;
    logic [ACC_W-1:0] ftw_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [7:0]       ph_q;
    logic [7:0]       step_q;
    logic             en_q;
    logic             sw_q;
    logic             i_q;
    logic             i_d;
    logic             q_q;
    logic             q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic [ACC_W-1:0] ph_ext;
    logic [ACC_W-1:0] p;
    logic [ACC_W:0]   sum;

    assign sel = cfg_wr && (cfg_addr[5:3] == 3'(c));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ftw_sh_q  <= '0;
        ph_sh_q   <= '0;
        step_sh_q <= '0;
        en_sh_q   <= 1'b0;
        sw_sh_q   <= 1'b0;
      end else if (sel) begin
        for (int b = 0; b < ACC_W/8; b++) begin
          if (cfg_addr[2:0] == 3'(b))
            ftw_sh_q[8*b +: 8] <= cfg_data;
        end
        case (cfg_addr[2:0])
          3'd4: ph_sh_q <= cfg_data;
          3'd5: begin
            en_sh_q <= cfg_data[0];
            sw_sh_q <= cfg_data[1];
          end
          3'd6: step_sh_q <= cfg_data;
          default: ;
        endcase
      end
    end

    assign ph_ext = ACC_W'(ph_q) << (ACC_W-8);
    assign p      = acc_q + ph_ext;
    assign sum    = {1'b0, ftw_q} + {{(ACC_W-7){1'b0}}, step_q};

    // MSB tests are written as compares so the whole phase word is consumed
    always_comb begin
      acc_d  = acc_q;
      ftw_d  = ftw_q;
      i_d    = i_q;
      q_d    = q_q;
      wrap_d = wrap_q;
      if (ena) begin
        i_d    = en_q & (p >= HALF);
        q_d    = en_q & ((p + QTR) >= HALF);
        acc_d  = en_q ? acc_q + ftw_q : '0;
        wrap_d = 1'b0;
        if (en_q && sw_q) begin
          if (sum[ACC_W]) begin
            ftw_d  = base_q;
            wrap_d = 1'b1;
          end else begin
            ftw_d = sum[ACC_W-1:0];
          end
        end
      end
      if (commit) begin
        ftw_d  = ftw_sh_q;
        wrap_d = 1'b0;
        if (cfg_data[0]) acc_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        base_q <= '0;
        ftw_q  <= '0;
        acc_q  <= '0;
        ph_q   <= '0;
        step_q <= '0;
        en_q   <= 1'b0;
        sw_q   <= 1'b0;
        i_q    <= 1'b0;
        q_q    <= 1'b0;
        wrap_q <= 1'b0;
      end else begin
        ftw_q  <= ftw_d;
        acc_q  <= acc_d;
        i_q    <= i_d;
        q_q    <= q_d;
        wrap_q <= wrap_d;
        if (commit) begin
          base_q <= ftw_sh_q;
          ph_q   <= ph_sh_q;
          step_q <= step_sh_q;
          en_q   <= en_sh_q;
          sw_q   <= sw_sh_q;
        end
      end
    end

    assign lo_i[c]       = i_q;
    assign lo_q[c]       = q_q;
    assign sweep_wrap[c] = wrap_q;
  end

endmodule
